mdio_phy_slave: RTL and testbench

MDIO_PHY_SLAVE -- requirements
Module: mdio_phy_slave

---
 rtl/mdio_phy_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_mdio_phy_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_slave.sv
// MDIO (clause 22) PHY-side slave: decodes master frames sampled on MDC rising
// edges, serves reads/writes from a 32 x 16 register file.
module mdio_phy_slave #(
  parameter logic [4:0]  PHY_ADDR = 5'd2,
  parameter logic [15:0] REG_INIT = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic        WR_STROBE,
  output logic [4:0]  WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        RD_STROBE,
  output logic        FRAME_ERR
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ST    = 4'd1;
  localparam logic [3:0] S_OP    = 4'd2;
  localparam logic [3:0] S_PHYAD = 4'd3;
  localparam logic [3:0] S_REGAD = 4'd4;
  localparam logic [3:0] S_TA    = 4'd5;
  localparam logic [3:0] S_WDATA = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_SKIP  = 4'd8;

  logic        mdc_q, mdc_d;
  logic [3:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] rd_sh_q, rd_sh_d;
  logic        rd_op_q, rd_op_d;
  logic        mdio_in_q, mdio_in_d;
  logic        mdio_in_oe_q, mdio_in_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];
  logic        rise;

  assign mdc_d = MDC;
  assign rise  = MDC & ~mdc_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phy_d        = phy_q;
    reg_d        = reg_q;
    sh_d         = sh_q;
    rd_sh_d      = rd_sh_q;
    rd_op_d      = rd_op_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_oe_d = mdio_in_oe_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;
    wr_strobe_d  = 1'b0;
    rd_strobe_d  = 1'b0;
    frame_err_d  = 1'b0;
    if (rise) begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (MDIO_OE && !MDIO_OUT) state_d = S_ST;
        end
        S_ST: begin
          cnt_d = '0;
          if (MDIO_OUT) begin
            state_d = S_OP;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_OP: begin
          if (cnt_q == 5'd0) begin
            sh_d[0] = MDIO_OUT;
            cnt_d   = 5'd1;
          end else if (sh_q[0] == MDIO_OUT) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            // OP 10 (first bit 1) is a read
            rd_op_d = sh_q[0];
            cnt_d   = '0;
            state_d = S_PHYAD;
          end
        end
        S_PHYAD: begin
          phy_d = {phy_q[3:0], MDIO_OUT};
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = S_REGAD;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_REGAD: begin
          reg_d = {reg_q[3:0], MDIO_OUT};
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = (phy_q == PHY_ADDR) ? S_TA : S_SKIP;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_TA: begin
          if (rd_op_q) begin
            if (MDIO_OE) begin
              frame_err_d  = 1'b1;
              mdio_in_oe_d = 1'b0;
              mdio_in_d    = 1'b0;
              state_d      = S_IDLE;
            end else if (cnt_q == 5'd0) begin
              rd_sh_d     = regs_q[reg_q];
              rd_strobe_d = 1'b1;
              cnt_d       = 5'd1;
            end else begin
              mdio_in_oe_d = 1'b1;
              mdio_in_d    = 1'b0;
              cnt_d        = '0;
              state_d      = S_RDATA;
            end
          end else if (cnt_q == 5'd0) begin
            sh_d[0] = MDIO_OUT;
            cnt_d   = 5'd1;
          end else if (sh_q[0] && !MDIO_OUT) begin
            cnt_d   = '0;
            state_d = S_WDATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_WDATA: begin
          sh_d = {sh_q[14:0], MDIO_OUT};
          if (cnt_q == 5'd15) begin
            regs_d[reg_q] = {sh_q[14:0], MDIO_OUT};
            wr_addr_d     = reg_q;
            wr_data_d     = {sh_q[14:0], MDIO_OUT};
            wr_strobe_d   = 1'b1;
            cnt_d         = '0;
            state_d       = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_RDATA: begin
          // cnt counts data bits already presented; 16 means the frame is done
          if (MDIO_OE || cnt_q == 5'd16) begin
            frame_err_d  = MDIO_OE;
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            cnt_d        = '0;
            state_d      = S_IDLE;
          end else begin
            mdio_in_d = rd_sh_q[15];
            rd_sh_d   = {rd_sh_q[14:0], 1'b0};
            cnt_d     = cnt_q + 5'd1;
          end
        end
        S_SKIP: begin
          if (cnt_q == 5'd17) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mdc_q        <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mdio_in_q    <= 1'b0;
      mdio_in_oe_q <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_strobe_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= REG_INIT;
    end else begin
      mdc_q        <= mdc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_oe_q <= mdio_in_oe_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_strobe_q  <= rd_strobe_d;
      frame_err_q  <= frame_err_d;
      regs_q       <= regs_d;
    end
  end

  // Field shift registers carry no control meaning outside their states.
  always_ff @(posedge CLK) begin
    phy_q   <= phy_d;
    reg_q   <= reg_d;
    sh_q    <= sh_d;
    rd_sh_q <= rd_sh_d;
    rd_op_q <= rd_op_d;
  end

  assign MDIO_IN    = mdio_in_q;
  assign MDIO_IN_OE = mdio_in_oe_q;
  assign WR_STROBE  = wr_strobe_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign RD_STROBE  = rd_strobe_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Bench for mdio_phy_slave: directed frame table, hand-written reset/contention
// sequences, then random frames checked against a field-level reference model.
module tb_mdio_phy_slave;

  localparam logic [4:0]  PHY = 5'd2;
  localparam logic [15:0] INIT = 16'hC35A;

  logic        CLK, RESET, MDC, MDIO_OUT, MDIO_OE;
  logic        MDIO_IN, MDIO_IN_OE, WR_STROBE, RD_STROBE, FRAME_ERR;
  logic [4:0]  WR_ADDR;
  logic [15:0] WR_DATA;

  mdio_phy_slave #(.PHY_ADDR(PHY), .REG_INIT(INIT)) dut (
    .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .MDIO_IN(MDIO_IN), .MDIO_IN_OE(MDIO_IN_OE), .WR_STROBE(WR_STROBE),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .RD_STROBE(RD_STROBE), .FRAME_ERR(FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int n_wr = 0, n_rd = 0, n_fe = 0;

  // Strobe cycles counted: a pulse wider than one CLK shows up as extra counts.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (WR_STROBE) n_wr++;
      if (RD_STROBE) n_rd++;
      if (FRAME_ERR) n_fe++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic mdc_bit(input logic oe, input logic b, output logic s_oe, output logic s_in);
    @(negedge CLK);
    MDIO_OE = oe;
    MDIO_OUT = b;
    repeat (3) @(negedge CLK);
    MDC = 1'b1;
    repeat (3) @(negedge CLK);
    s_oe = MDIO_IN_OE;
    s_in = MDIO_IN;
    MDC = 1'b0;
  endtask

  // Rise i of the frame lands at bit position 32-i of the sampled vectors.
  task automatic send_frame(input logic [31:0] word, input int drv, input int pre, input int cont,
                            output logic [32:0] s_oe, output logic [32:0] s_in);
    logic [31:0] w;
    logic a, b;
    w = word;
    s_oe = '0;
    s_in = '0;
    for (int p = 0; p < pre; p++) mdc_bit(1'b1, 1'b1, a, b);
    for (int i = 0; i <= 32; i++) begin
      mdc_bit((i < drv) || (i == cont), (i < 32) ? w[31] : 1'b1, a, b);
      w = {w[30:0], 1'b0};
      s_oe = {s_oe[31:0], a};
      s_in = {s_in[31:0], b};
    end
  endtask

  task automatic do_frame(input string tag, input logic [31:0] word, input int drv, input int pre,
                          input int cont, input int e_wr, input int e_rd, input int e_fe,
                          input logic [32:0] e_oe, input logic [32:0] e_in,
                          input logic [4:0] e_wa, input logic [15:0] e_wd);
    int w0, r0, f0;
    logic [32:0] so, si;
    w0 = n_wr; r0 = n_rd; f0 = n_fe;
    send_frame(word, drv, pre, cont, so, si);
    check({tag, "_oe"}, 64'(so), 64'(e_oe));
    check({tag, "_in"}, 64'(si), 64'(e_in));
    check({tag, "_wr"}, 64'(n_wr - w0), 64'(e_wr));
    check({tag, "_rd"}, 64'(n_rd - r0), 64'(e_rd));
    check({tag, "_fe"}, 64'(n_fe - f0), 64'(e_fe));
    check({tag, "_wa"}, 64'(WR_ADDR), 64'(e_wa));
    check({tag, "_wd"}, 64'(WR_DATA), 64'(e_wd));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_oe"}, 64'(MDIO_IN_OE), 64'(0));
    check({tag, "_in"},    64'(MDIO_IN),    64'(0));
    check({tag, "_wrs"},   64'(WR_STROBE),  64'(0));
    check({tag, "_rds"},   64'(RD_STROBE),  64'(0));
    check({tag, "_fe"},    64'(FRAME_ERR),  64'(0));
    check({tag, "_wa"},    64'(WR_ADDR),    64'(0));
    check({tag, "_wd"},    64'(WR_DATA),    64'(0));
  endtask

  typedef struct {
    logic [31:0] word;
    int          drv;
    int          pre;
    int          e_wr, e_rd, e_fe;
    logic [32:0] e_oe, e_in;
    logic [4:0]  e_wa;
    logic [15:0] e_wd;
  } vec_t;

  vec_t tbl [11];

  // Reference model state
  logic [15:0] mem [32];
  logic [4:0]  m_wa;
  logic [15:0] m_wd;

  initial begin
    logic [1:0]  st, op, ta;
    logic [4:0]  phy, ra;
    logic [15:0] data;
    logic [31:0] word;
    logic [32:0] e_oe, e_in, so, si;
    int kind, drv, cont, e_wr, e_rd, e_fe, climit, w0;
    logic a, b;

    tbl[0]  = '{32'h5112ABCD, 32, 0,  1, 0, 0, 33'h0,     33'h0,     5'd4,  16'hABCD};
    tbl[1]  = '{32'h61115F1F, 14, 0,  0, 1, 0, 33'h3FFFE, 33'h1579A, 5'd4,  16'hABCD};
    tbl[2]  = '{32'h61915F1F, 14, 0,  0, 0, 0, 33'h0,     33'h0,     5'd4,  16'hABCD};
    tbl[3]  = '{32'h61115F1F, 14, 32, 0, 1, 0, 33'h3FFFE, 33'h1579A, 5'd4,  16'hABCD};
    tbl[4]  = '{32'h00000000, 2,  0,  0, 0, 1, 33'h0,     33'h0,     5'd4,  16'hABCD};
    tbl[5]  = '{32'h70000000, 4,  0,  0, 0, 1, 33'h0,     33'h0,     5'd4,  16'hABCD};
    tbl[6]  = '{32'h40000000, 4,  0,  0, 0, 1, 33'h0,     33'h0,     5'd4,  16'hABCD};
    tbl[7]  = '{32'h51131234, 16, 0,  0, 0, 1, 33'h0,     33'h0,     5'd4,  16'hABCD};
    tbl[8]  = '{32'h517E0F0F, 32, 0,  1, 0, 0, 33'h0,     33'h0,     5'd31, 16'h0F0F};
    tbl[9]  = '{32'h617D0000, 14, 0,  0, 1, 0, 33'h3FFFE, 33'h1E1E,  5'd31, 16'h0F0F};
    tbl[10] = '{32'h61150000, 14, 0,  0, 1, 0, 33'h3FFFE, 33'h186B4, 5'd31, 16'h0F0F};

    RESET = 1'b1; MDC = 1'b0; MDIO_OUT = 1'b1; MDIO_OE = 1'b0;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    for (int k = 0; k < 11; k++)
      do_frame($sformatf("tbl%0d", k), tbl[k].word, tbl[k].drv, tbl[k].pre, -1,
               tbl[k].e_wr, tbl[k].e_rd, tbl[k].e_fe, tbl[k].e_oe, tbl[k].e_in,
               tbl[k].e_wa, tbl[k].e_wd);

    // Reset in the middle of a write to reg 4 (after 8 data bits).
    w0 = n_wr;
    word = 32'h51121111;
    for (int i = 0; i < 24; i++) begin
      mdc_bit(1'b1, word[31], a, b);
      word = {word[30:0], 1'b0};
    end
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check_outputs_zero("midreset");
    MDIO_OE = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("midreset_nowr", 64'(n_wr - w0), 64'(0));
    do_frame("rd_after_reset", 32'h61115F1F, 14, 0, -1, 0, 1, 0,
             33'h3FFFE, 33'(INIT) << 1, 5'd0, 16'h0000);

    // Master drives during data rise 20 of a read: bits D15..D12 of INIT already out.
    do_frame("contention", 32'h61115F1F, 14, 0, 20, 0, 1, 1,
             33'h3E000, 33'h18000, 5'd0, 16'h0000);

    // Master drives during the first turnaround rise: no latch, no drive.
    do_frame("cont_ta1", 32'h61115F1F, 14, 0, 14, 0, 0, 1,
             33'h0, 33'h0, 5'd0, 16'h0000);

    for (int r = 0; r < 32; r++) mem[r] = INIT;
    m_wa = '0;
    m_wd = '0;

    for (int n = 0; n < 70; n++) begin
      kind = int'($urandom_range(0, 6));
      ra   = 5'($urandom_range(0, 31));
      data = 16'($urandom);
      phy  = PHY;
      st   = 2'b01;
      ta   = 2'b10;
      op   = (kind == 1 || kind == 6) ? 2'b10 : 2'b01;
      if (kind == 2) begin
        st = 2'b00;
        op = 2'($urandom_range(0, 3));
      end
      if (kind == 3) op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      if (kind == 4) ta = ($urandom_range(0, 2) == 0) ? 2'b00 :
                          (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
      if (kind == 5) begin
        phy = 5'($urandom_range(0, 31));
        if (phy == PHY) phy = PHY + 5'd1;
        op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      end
      if (op == 2'b10) ta = 2'b01;
      cont = (kind == 6) ? int'($urandom_range(14, 31)) : -1;
      word = {st, op, phy, ra, ta, data};

      e_wr = 0; e_rd = 0; e_fe = 0; e_oe = '0; e_in = '0;
      if (st != 2'b01) begin
        e_fe = 1; drv = 2;
      end else if (op == 2'b00 || op == 2'b11) begin
        e_fe = 1; drv = 4;
      end else if (phy != PHY) begin
        drv = (op == 2'b01) ? 32 : 14;
      end else if (op == 2'b01) begin
        if (ta != 2'b10) begin
          e_fe = 1; drv = 16;
        end else begin
          drv = 32; e_wr = 1;
          mem[ra] = data; m_wa = ra; m_wd = data;
        end
      end else begin
        drv = 14;
        e_rd = (cont == 14) ? 0 : 1;
        e_fe = (cont >= 0) ? 1 : 0;
        climit = (cont < 0) ? 33 : cont;
        for (int i = 15; i <= 31; i++) begin
          if (i < climit) begin
            e_oe[32 - i] = 1'b1;
            if (i >= 16) e_in[32 - i] = mem[ra][31 - i];
          end
        end
      end
      do_frame($sformatf("rnd%0d_k%0d", n, kind), word, drv, int'($urandom_range(0, 4)), cont,
               e_wr, e_rd, e_fe, e_oe, e_in, m_wa, m_wd);
    end

    // Sweep-read every register to confirm the file matches the model.
    for (int r = 0; r < 32; r++) begin
      word = {2'b01, 2'b10, PHY, 5'(r), 2'b01, 16'h0};
      e_in = 33'(mem[r]) << 1;
      do_frame($sformatf("sweep%0d", r), word, 14, 0, -1, 0, 1, 0,
               33'h3FFFE, e_in, m_wa, m_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
